bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits directly upstream of the multiplexed seven-segment display driver.
//   Converts a binary count, e.g. from the 1 s counter, into packed BCD digits.
//   The display can then show decimal values instead of a single hex nibble.
// PARAMETERS
//   BIN_WIDTH  27  width of binary input; 27 bits covers 0..99_999_999
//   DIGITS     8   number of BCD digits produced, one per display anode
// PORTS
//   clock     in   1            system clock, all logic on rising edge
//   reset     in   1            asynchronous, active-low reset
//   start     in   1            request conversion of bin; sampled only in IDLE
//   bin       in   BIN_WIDTH    binary value, captured on accepted start
//   busy      out  1            high while a conversion is in progress (SHIFT)
//   done      out  1            one-cycle pulse, bcd/overflow valid and updated
//   bcd       out  4*DIGITS     packed BCD; digit0 = bcd[3:0] (least significant)
//   overflow  out  1            last converted bin >= 10**DIGITS
// BEHAVIOUR
//   - reset low (async): state=IDLE, busy=0, done=0, bcd=0, overflow=0,
//     internal shift reg/scratch/bit counter cleared; in-flight conversion aborted.
//   - FSM states: IDLE, SHIFT, DONE.
//     IDLE  : start=1 -> latch bin into shift reg, clear BCD scratch and ovf flag,
//             bit counter=BIN_WIDTH, go SHIFT. start=0 -> stay.
//     SHIFT : each cycle: for every scratch digit >=5 add 3 (all digits in
//             parallel, same cycle), then shift {scratch,shiftreg} left by 1.
//             Bit shifted out of top digit ORs into ovf flag. Decrement counter;
//             on the cycle counter reaches 1 -> go DONE.
//     DONE  : bcd <= ovf ? all digits 4'h9 : scratch; overflow <= ovf;
//             done=1 for exactly this cycle; next state IDLE.
//   - busy=1 exactly in SHIFT (BIN_WIDTH cycles). done is registered, not comb.
//   - Latency: start sampled at edge 0 -> done high in cycle BIN_WIDTH+1
//     (28 for default). bcd/overflow change only in the done cycle and otherwise
//     hold the last result (display never sees partial values).
//   - start while busy or in DONE is ignored (no queueing); new start is
//     accepted from IDLE, so min start-to-start spacing is BIN_WIDTH+2 cycles.
//   - bin changes after acceptance have no effect on the running conversion.
//   - Overflow saturates output to 99..9 so the display never shows garbage.
//   - If BIN_WIDTH cannot exceed 10**DIGITS-1, overflow is constant 0.
//   - Counter width = $clog2(BIN_WIDTH+1); no wrap-around possible in SHIFT.
// TESTING
//   1. bin=0, start pulse -> done in cycle 28, bcd=32'h00000000, overflow=0.
//   2. bin=12_345_678 -> bcd=32'h12345678, overflow=0; busy high 27 cycles.
//   3. bin=99_999_999 -> bcd=32'h99999999, overflow=0; then
//      bin=100_000_000 -> bcd=32'h99999999, overflow=1.
//   4. start held high continuously, bin=42 -> conversions every 29 cycles,
//      each bcd=32'h00000042; pulses during SHIFT/DONE do not restart.
//   5. bin=7 then change bin to 9 mid-SHIFT -> result bcd=32'h00000007.
//   6. reset low at SHIFT cycle 10 (prior bcd=0x00000123) -> bcd=0, busy=0,
//      no done; after release, bin=5 start -> bcd=32'h00000005 in 28 cycles.
//   Also random bin sweep vs. reference model, checking done-cycle timing.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Results are loaded into bcd/overflow only when done pulses, so the display never sees partial values.
module bin2bcd_seq #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    // Overflow is only reachable when 2**BIN_WIDTH exceeds 10**DIGITS.
    localparam bit CAN_OVF = ((64'd1 << BIN_WIDTH) > (64'd10 ** DIGITS));

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [BIN_WIDTH-1:0]   shreg, nxt_shreg;
    logic [4*DIGITS-1:0]    scratch, adj, nxt_scratch;
    logic [CW-1:0]          cnt;
    logic                   ovf_f, nxt_ovf, done_r, last_bit;

    // Add-3 correction on every digit in parallel before the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                            : scratch[4*d +: 4];
    end

    assign nxt_scratch = {adj[4*DIGITS-2:0], shreg[BIN_WIDTH-1]};
    assign nxt_shreg   = shreg << 1;
    assign nxt_ovf     = CAN_OVF ? (ovf_f | adj[4*DIGITS-1]) : 1'b0;
    assign last_bit    = (cnt == CW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The result registers are loaded on the final shift edge so that they
    // become visible together with done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_f    <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shreg   <= bin;
                    scratch <= '0;
                    ovf_f   <= 1'b0;
                    cnt     <= CW'(BIN_WIDTH);
                end
                SHIFT: begin
                    shreg   <= nxt_shreg;
                    scratch <= nxt_scratch;
                    ovf_f   <= nxt_ovf;
                    cnt     <= cnt - 1'b1;
                    if (last_bit) begin
                        bcd      <= nxt_ovf ? {DIGITS{4'h9}} : nxt_scratch;
                        overflow <= nxt_ovf;
                        done_r   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = done_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a cycle model predicts accepts and done timing,
// and expected results are queued at accept and compared when done is seen.
module tb_bin2bcd_seq;

    localparam int BW = 27;
    localparam int DG = 8;

    typedef struct {
        logic [4*DG-1:0] bcd;
        logic            ovf;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [BW-1:0]   bin   = '0;
    logic            busy, done, overflow;
    logic [4*DG-1:0] bcd;

    int errs = 0;
    int checks = 0;

    exp_t            sb[$];
    int              ph = 0;          // 0 idle, 1..BW shifting, BW+1 done cycle
    int              busy_cnt = 0;
    logic [4*DG-1:0] last_bcd = '0;
    logic            last_ovf = 1'b0;

    bin2bcd_seq #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .clock(clock), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_conv(input longint unsigned v);
        exp_t e;
        longint unsigned t;
        e.bcd = '0;
        e.ovf = 1'b0;
        if (v >= 64'd100_000_000) begin
            e.ovf = 1'b1;
            e.bcd = {DG{4'h9}};
        end else begin
            t = v;
            for (int i = 0; i < DG; i++) begin
                e.bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return e;
    endfunction

    // Cycle-level acceptance / timing model driven by the same inputs as the DUT.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph = 0;
            sb.delete();
            last_bcd = '0;
            last_ovf = 1'b0;
            busy_cnt = 0;
        end else if (ph == 0) begin
            if (start) begin
                sb.push_back(ref_conv(longint'(bin)));
                ph = 1;
                busy_cnt = 0;
            end
        end else if (ph == BW + 1) begin
            ph = 0;
        end else begin
            ph++;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        chk("busy", busy, (ph >= 1 && ph <= BW));
        chk("done", done, (ph == BW + 1));
        if (busy) busy_cnt++;
        if (ph == BW + 1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("bcd", bcd, e.bcd);
                chk("overflow", overflow, e.ovf);
                chk("busy_len", busy_cnt, BW);
                last_bcd = e.bcd;
                last_ovf = e.ovf;
            end
        end else begin
            chk("hold", {overflow, bcd}, {last_ovf, last_bcd});
        end
    end

    task automatic conv(input logic [BW-1:0] v);
        @(posedge clock); #1;
        bin = v; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && ph != 0; i++) @(posedge clock);
        chk("idle_timeout", (ph == 0), 1);
        @(posedge clock);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);

        conv(27'd0);            wait_idle();
        conv(27'd12_345_678);   wait_idle();
        conv(27'd99_999_999);   wait_idle();
        conv(27'd100_000_000);  wait_idle();
        conv(27'(2**BW - 1));   wait_idle();
        conv(27'd99_999_998);   wait_idle();

        // start held high: back-to-back conversions every BW+2 cycles
        @(posedge clock); #1;
        bin = 27'd42; start = 1'b1;
        repeat (3 * (BW + 2)) @(posedge clock);
        #1 start = 1'b0;
        wait_idle();

        // input changes after acceptance must not affect the result
        conv(27'd7);
        repeat (5) @(posedge clock);
        #1 bin = 27'd9;
        wait_idle();

        // reset in mid-conversion aborts it and clears the result
        conv(27'd123);          wait_idle();
        conv(27'd555);
        repeat (9) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        conv(27'd5);            wait_idle();

        for (int i = 0; i < 20; i++) begin
            conv(27'($urandom));
            wait_idle();
        end

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
